// File: rtl/ttseq_pkg.sv
// ttseq_pkg: shared state encoding and sizing for the truth-table sequencer
package ttseq_pkg;
  localparam int NUM_VECTORS = 32;
  localparam int VEC_W = 5;
  localparam logic [NUM_VECTORS-1:0] DEFAULT_GOLDEN = 32'hFFFF50F7;
  typedef enum logic [2:0] {IDLE, S_DRIVE, S_SAMPLE, S_DONE, Q_DRIVE, Q_RESP} state_t;
endpackage

// File: rtl/odev1_devre.sv
// odev1_devre: 5-input combinational function under evaluation (truth table 32'hFFFF50F7)
module odev1_devre (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  output logic F
);
  assign F = A | (~B & (C | ~(D & E))) | (B & C & ~E);
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps or queries odev1_devre, building a truth table and golden match
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter logic [NUM_VECTORS-1:0] GOLDEN = DEFAULT_GOLDEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic [5:0]             ones_count,
  output logic                   match,
  input  logic                   q_valid,
  input  logic [VEC_W-1:0]       q_vec,
  output logic                   q_ready,
  output logic                   q_resp_valid,
  output logic                   q_resp_f
);
  state_t stateQ, stateD;
  logic [VEC_W-1:0] vecQ;
  logic [3:0] settleCnt;
  logic settleDone, f;
  odev1_devre uFunc (.A(vecQ[4]), .B(vecQ[3]), .C(vecQ[2]), .D(vecQ[1]), .E(vecQ[0]), .F(f));
  assign settleDone = settleCnt == 4'(SETTLE_CYCLES - 1);
  assign busy = stateQ != IDLE;
  assign done = stateQ == S_DONE;
  assign q_resp_valid = stateQ == Q_RESP;
  assign q_ready = stateQ == IDLE && !start && q_valid;
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:     stateD = start ? S_DRIVE : q_valid ? Q_DRIVE : IDLE;
      S_DRIVE:  stateD = settleDone ? S_SAMPLE : S_DRIVE;
      S_SAMPLE: stateD = vecQ == VEC_W'(NUM_VECTORS - 1) ? S_DONE : S_DRIVE;
      Q_DRIVE:  stateD = settleDone ? Q_RESP : Q_DRIVE;
      default:  stateD = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else stateQ <= stateD;
  end
  // match is resolved on the last sample so it is already valid during the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vecQ <= '0;
      settleCnt <= '0;
      table_out <= '0;
      ones_count <= '0;
      match <= 1'b0;
      q_resp_f <= 1'b0;
    end else begin
      settleCnt <= ((stateQ == S_DRIVE || stateQ == Q_DRIVE) && !settleDone) ? settleCnt + 4'd1 : '0;
      case (stateQ)
        IDLE: begin
          if (start) begin
            vecQ <= '0;
            table_out <= '0;
            ones_count <= '0;
            match <= 1'b0;
          end else if (q_valid) vecQ <= q_vec;
        end
        S_SAMPLE: begin
          table_out[vecQ] <= f;
          ones_count <= ones_count + 6'(f);
          if (vecQ == VEC_W'(NUM_VECTORS - 1)) match <= {f, table_out[NUM_VECTORS-2:0]} == GOLDEN;
          else vecQ <= vecQ + 1'b1;
        end
        Q_DRIVE: if (settleDone) q_resp_f <= f;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: vector table, random queries and sweep corner cases vs a truth-table model
module tb_truth_table_sequencer;
  import ttseq_pkg::*;
  localparam logic [31:0] REF_TABLE = 32'hFFFF50F7;
  logic clk = 0, rst_n = 0, start = 0, q_valid = 0;
  logic [4:0] q_vec = '0;
  logic busy, done, match, q_ready, q_resp_valid, q_resp_f;
  logic [31:0] table_out;
  logic [5:0] ones_count;
  logic bBusy, bDone, bMatch, bReady, bRespValid, bRespF;
  logic [31:0] bTable;
  logic [5:0] bOnes;
  int checks = 0, errors = 0;
  typedef struct { logic [4:0] vec; logic f; } qvec_t;
  qvec_t tbl [8];
  truth_table_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .table_out(table_out),
    .ones_count(ones_count), .match(match), .q_valid(q_valid), .q_vec(q_vec), .q_ready(q_ready),
    .q_resp_valid(q_resp_valid), .q_resp_f(q_resp_f)
  );
  truth_table_sequencer #(.GOLDEN(32'hFFFF50F6)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(bBusy), .done(bDone), .table_out(bTable),
    .ones_count(bOnes), .match(bMatch), .q_valid(q_valid), .q_vec(q_vec), .q_ready(bReady),
    .q_resp_valid(bRespValid), .q_resp_f(bRespF)
  );
  always #5 clk = ~clk;
  function automatic logic refF(input logic [4:0] v);
    logic [31:0] t;
    t = REF_TABLE;
    return t[v];
  endfunction
  function automatic int refOnes();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += refF(5'(i));
    return n;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic sweep(input int restartAt, input bit hold, output int lat, output int readyHits);
    lat = 0;
    readyHits = 0;
    @(negedge clk);
    start = 1;
    if (hold) begin
      q_valid = 1;
      q_vec = 5'd3;
    end
    #1 readyHits += int'(q_ready);
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      @(negedge clk);
      start = (n == restartAt);
      #1 readyHits += int'(q_ready);
      if (done) lat = n;
    end
  endtask
  task automatic query(input logic [4:0] v, input logic expF);
    int lat;
    @(negedge clk);
    q_valid = 1;
    q_vec = v;
    #1 chk("q_ready on accept", q_ready, 1);
    chk("no done while idle", done, 0);
    @(negedge clk);
    q_valid = 0;
    q_vec = 5'($urandom);
    lat = 1;
    while (!q_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("query latency", lat, 2);
    chk($sformatf("q_resp_f vec %0d", v), q_resp_f, expF);
    @(negedge clk);
    chk("q_resp_valid pulse", q_resp_valid, 0);
    chk("q_resp_f hold", q_resp_f, expF);
  endtask
  task automatic checkTable(input string tag);
    chk({tag, " table_out"}, table_out, REF_TABLE);
    chk({tag, " ones_count"}, ones_count, refOnes());
    chk({tag, " match"}, match, 1);
    chk({tag, " busy"}, busy, 0);
  endtask
  initial begin
    int lat, hits;
    logic [4:0] v;
    tbl[0] = '{5'd3, 1'b0};  tbl[1] = '{5'd12, 1'b1}; tbl[2] = '{5'd0, 1'b1};  tbl[3] = '{5'd8, 1'b0};
    tbl[4] = '{5'd13, 1'b0}; tbl[5] = '{5'd31, 1'b1}; tbl[6] = '{5'd16, 1'b1}; tbl[7] = '{5'd7, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset table", table_out, 0);
    chk("reset ones", ones_count, 0);
    chk("reset match/done/resp", {match, done, q_ready, q_resp_valid, q_resp_f}, 0);
    rst_n = 1;
    sweep(0, 0, lat, hits);
    chk("sweep latency", lat, 65);
    chk("match in done cycle", match, 1);
    chk("golden override match", bMatch, 0);
    chk("golden override table", bTable, REF_TABLE);
    chk("golden override ones", bOnes, 25);
    @(negedge clk);
    chk("done single pulse", done, 0);
    checkTable("sweep1");
    for (int i = 0; i < 8; i++) query(tbl[i].vec, tbl[i].f);
    for (int i = 0; i < 16; i++) begin
      v = 5'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      query(v, refF(v));
    end
    checkTable("after queries");
    sweep(0, 1, lat, hits);
    chk("held query latency", lat, 65);
    chk("q_ready while start/busy", hits, 0);
    query(5'd3, 1'b0);
    checkTable("after held query");
    sweep(10, 0, lat, hits);
    chk("restart ignored latency", lat, 65);
    @(negedge clk);
    chk("restart no extra done", done, 0);
    checkTable("restart");
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (28) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("abort busy", busy, 0);
    chk("abort table", table_out, 0);
    chk("abort ones", ones_count, 0);
    chk("abort flags", {done, match, q_ready, q_resp_valid, q_resp_f}, 0);
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      hits += int'(done) + int'(busy);
    end
    chk("no done during reset", hits, 0);
    rst_n = 1;
    sweep(0, 0, lat, hits);
    chk("post-reset sweep latency", lat, 65);
    @(negedge clk);
    checkTable("post-reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Clocked controller that owns one instance of the 5-input combinational function block `odev1_devre` (inputs A..E, output F).
- Two masters share that block:
  - Exhaustive sweep: applies all 32 input vectors, captures F into a 32-bit truth table, counts ones and compares against a golden table.
  - Single-vector query port with a valid/ready handshake.
- Sits between the test/control logic and the combinational function under evaluation.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held on A..E before F is sampled; legal range 1..15.
- GOLDEN, 32'hFFFF50F7, expected truth table; bit i = F for vector i.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a full sweep.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  32  captured truth table; bit i = F({A,B,C,D,E}=i).
- ones_count  output  6  popcount of table_out (0..32).
- match  output  1  table_out == GOLDEN; valid from done onward.
- q_valid  input  1  query request.
- q_vec  input  5  query vector {A,B,C,D,E}.
- q_ready  output  1  query accepted this cycle.
- q_resp_valid  output  1  one-cycle pulse, query result valid.
- q_resp_f  output  1  F value for the accepted q_vec.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; vector register = 0; settle counter = 0.
  - busy, done, match, q_ready, q_resp_valid, q_resp_f = 0.
  - table_out = 0, ones_count = 0.
- Vector register drives A..E of `odev1_devre` directly. The vector is registered, so A..E never glitch mid-settle.
- Index mapping: A = bit4 (MSB) … E = bit0.
- FSM states: IDLE, S_DRIVE, S_SAMPLE, S_DONE, Q_DRIVE, Q_RESP.
- IDLE:
  - start=1 → load vec=0, clear table_out and ones_count, clear match, go to S_DRIVE.
  - Otherwise, q_valid=1 → q_ready=1 (combinational, IDLE and start=0 only), latch q_vec, go to Q_DRIVE.
  - start has priority over q_valid in the same cycle; q_ready stays 0 and the query waits.
- S_DRIVE: hold vec for SETTLE_CYCLES cycles (counter from 0 to SETTLE_CYCLES-1), then go to S_SAMPLE.
- S_SAMPLE:
  - table_out[vec] <= F.
  - ones_count <= ones_count + F (6-bit, cannot overflow).
  - If vec==31, go to S_DONE; else vec <= vec+1 and go to S_DRIVE.
  - vec is 5-bit and never wraps during a sweep.
- S_DONE:
  - done=1 for exactly one cycle.
  - match <= ({table_out} == GOLDEN), using the final table including bit 31.
  - Go to IDLE.
  - table_out, ones_count and match hold until the next start.
- Q_DRIVE: hold latched vector for SETTLE_CYCLES cycles, then go to Q_RESP.
- Q_RESP: q_resp_valid=1 and q_resp_f=F for one cycle, then go to IDLE. q_resp_f holds its value afterwards.
- Latency:
  - Sweep: start cycle to done cycle = 32*(SETTLE_CYCLES+1)+1 cycles (65 with default).
  - Query: accept cycle to q_resp_valid = SETTLE_CYCLES+1 cycles.
- Ignored inputs:
  - start while busy is ignored; no restart.
  - q_valid while busy gets q_ready=0; the requester must hold q_valid and q_vec until q_ready.
- Queries never corrupt table_out, ones_count or match.
- rst_n asserted mid-sweep or mid-query aborts immediately to reset values. No done or q_resp_valid is produced for the aborted operation.

Decomposition:
- Shared package `ttseq_pkg` holds:
  - FSM state enum.
  - NUM_VECTORS = 32 and VEC_W = 5.
  - Default GOLDEN constant.
- One sub-module is natural: the existing `odev1_devre`, instantiated once and driven from the vector register.
- Settle counter and popcount accumulation stay inline.

Test Plan:
- Reset, then one start pulse, default params → done exactly 65 cycles after start; table_out=32'hFFFF50F7, ones_count=25, match=1.
- GOLDEN=32'hFFFF50F6 override, same sweep → table_out=32'hFFFF50F7, match=0, ones_count=25.
- Idle query q_vec=5'b00011 (A=B=C=0, D=E=1) → q_ready same cycle, q_resp_f=0 after 2 cycles. Query q_vec=5'b01100 → q_resp_f=1.
- start and q_valid asserted in the same idle cycle (q_vec=5'd3, held) → sweep runs with q_ready=0 throughout. Query is accepted in the first idle cycle after done, returns 0, and table_out is unchanged.
- start pulsed again at cycle 10 of a sweep → ignored; single done at cycle 65, values as in the first scenario.
- rst_n driven low at cycle 30 of a sweep → all outputs 0 asynchronously, no done pulse. A new start after release → full correct sweep.
